// File: rtl/dram_cmd_sched_if.sv
// Request/command bundle between the request queue, dram_cmd_sched and the stats logic.
// opcode encoding: 0 = READ, 1 = WRITE, 2 = IFETCH.
interface dram_cmd_sched_if;

   typedef struct packed {
      logic [1:0]  opcode;
      logic [32:0] address;
      logic [63:0] CPU_clock_count;
   } parser_out_struct;

   parser_out_struct req;
   logic             req_valid;
   logic             req_ready;
   logic             cmd_valid;
   logic [1:0]       cmd;
   logic             cmd_wr;
   logic [1:0]       cmd_bank;
   logic [14:0]      cmd_row;
   logic [9:0]       cmd_col;
   logic             done;
   logic [15:0]      drop_cnt;

   modport master (
      output req, req_valid,
      input  req_ready, cmd_valid, cmd, cmd_wr, cmd_bank, cmd_row, cmd_col, done, drop_cnt
   );

   modport slave (
      input  req, req_valid,
      output req_ready, cmd_valid, cmd, cmd_wr, cmd_bank, cmd_row, cmd_col, done, drop_cnt
   );

endinterface

// File: rtl/dram_cmd_sched.sv
// Open-page DRAM command scheduler: PRE/ACT/CAS sequencing with tRP/tRCD/tCAS/tBURST spacing.
// Define CMD_TRACE_EN to compile in $display tracing of commands and dropped requests.
module dram_cmd_sched #(
   parameter int ADDR_W    = 33,
   parameter int NUM_BANKS = 4,
   parameter int T_RP      = 4,
   parameter int T_RCD     = 4,
   parameter int T_CAS     = 6,
   parameter int T_BURST   = 4
) (
   input logic CPU_clock,
   input logic rst_n,
   dram_cmd_sched_if.slave bus
);

   localparam logic [1:0] CMD_NOP  = 2'd0;
   localparam logic [1:0] CMD_PRE  = 2'd1;
   localparam logic [1:0] CMD_ACT  = 2'd2;
   localparam logic [1:0] CMD_CAS  = 2'd3;
   localparam logic [1:0] OP_WRITE = 2'd1;

   // Wait counters load T-1 on issue so the next command lands exactly T cycles later.
   localparam logic [7:0] RP_LD   = 8'(T_RP - 1);
   localparam logic [7:0] RCD_LD  = 8'(T_RCD - 1);
   localparam logic [7:0] DATA_LD = 8'(T_CAS + T_BURST - 1);

   if (T_RP < 1 || T_RP > 255 || T_RCD < 1 || T_RCD > 255 ||
       T_CAS < 1 || T_BURST < 1 || (T_CAS + T_BURST) > 255) begin : g_bad_timing
      $error("dram_cmd_sched: timing parameters out of range");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_PRE, S_ACT, S_CAS, S_WAIT_RP, S_WAIT_RCD, S_WAIT_DATA
   } state_t;

   state_t               state;
   logic [7:0]           wait_cnt;
   logic [NUM_BANKS-1:0] bank_open;
   logic [14:0]          bank_row [NUM_BANKS];

   logic                 req_ready_q;
   logic                 cmd_valid_q;
   logic [1:0]           cmd_q;
   logic                 cmd_wr_q;
   logic [1:0]           cmd_bank_q;
   logic [14:0]          cmd_row_q;
   logic [9:0]           cmd_col_q;
   logic                 done_q;
   logic [15:0]          drop_cnt_q;

   logic [1:0]           req_bank;
   logic [14:0]          req_row;
   logic [9:0]           req_col;
   logic                 req_wr;

   assign req_bank = bus.req.address[7:6];
   assign req_row  = bus.req.address[ADDR_W-1:18];
   assign req_col  = bus.req.address[17:8];
   assign req_wr   = (bus.req.opcode == OP_WRITE);

   always_ff @(posedge CPU_clock or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         wait_cnt    <= '0;
         bank_open   <= '0;
         bank_row    <= '{default: '0};
         req_ready_q <= 1'b0;
         cmd_valid_q <= 1'b0;
         cmd_q       <= CMD_NOP;
         cmd_wr_q    <= 1'b0;
         cmd_bank_q  <= '0;
         cmd_row_q   <= '0;
         cmd_col_q   <= '0;
         done_q      <= 1'b0;
         drop_cnt_q  <= '0;
      end else begin
         cmd_valid_q <= 1'b0;
         cmd_q       <= CMD_NOP;
         done_q      <= 1'b0;

         if (bus.req_valid && !req_ready_q && drop_cnt_q != '1)
            drop_cnt_q <= drop_cnt_q + 16'd1;

         unique case (state)
            S_IDLE: begin
               req_ready_q <= 1'b1;
               if (bus.req_valid && req_ready_q) begin
                  req_ready_q <= 1'b0;
                  cmd_valid_q <= 1'b1;
                  cmd_wr_q    <= req_wr;
                  cmd_bank_q  <= req_bank;
                  cmd_row_q   <= req_row;
                  cmd_col_q   <= req_col;
                  if (bank_open[req_bank] && bank_row[req_bank] == req_row) begin
                     state    <= S_CAS;
                     cmd_q    <= CMD_CAS;
                     wait_cnt <= DATA_LD;
                  end else if (bank_open[req_bank]) begin
                     state               <= S_PRE;
                     cmd_q               <= CMD_PRE;
                     wait_cnt            <= RP_LD;
                     bank_open[req_bank] <= 1'b0;
                  end else begin
                     state               <= S_ACT;
                     cmd_q               <= CMD_ACT;
                     wait_cnt            <= RCD_LD;
                     bank_open[req_bank] <= 1'b1;
                     bank_row[req_bank]  <= req_row;
                  end
               end
            end

            S_PRE, S_WAIT_RP: begin
               if (wait_cnt == '0) begin
                  state                 <= S_ACT;
                  cmd_valid_q           <= 1'b1;
                  cmd_q                 <= CMD_ACT;
                  wait_cnt              <= RCD_LD;
                  bank_open[cmd_bank_q] <= 1'b1;
                  bank_row[cmd_bank_q]  <= cmd_row_q;
               end else begin
                  state    <= S_WAIT_RP;
                  wait_cnt <= wait_cnt - 8'd1;
               end
            end

            S_ACT, S_WAIT_RCD: begin
               if (wait_cnt == '0) begin
                  state       <= S_CAS;
                  cmd_valid_q <= 1'b1;
                  cmd_q       <= CMD_CAS;
                  wait_cnt    <= DATA_LD;
               end else begin
                  state    <= S_WAIT_RCD;
                  wait_cnt <= wait_cnt - 8'd1;
               end
            end

            S_CAS, S_WAIT_DATA: begin
               if (wait_cnt == '0) begin
                  state       <= S_IDLE;
                  done_q      <= 1'b1;
                  req_ready_q <= 1'b1;
               end else begin
                  state    <= S_WAIT_DATA;
                  wait_cnt <= wait_cnt - 8'd1;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.cmd_valid = cmd_valid_q;
   assign bus.cmd       = cmd_q;
   assign bus.cmd_wr    = cmd_wr_q;
   assign bus.cmd_bank  = cmd_bank_q;
   assign bus.cmd_row   = cmd_row_q;
   assign bus.cmd_col   = cmd_col_q;
   assign bus.done      = done_q;
   assign bus.drop_cnt  = drop_cnt_q;

`ifdef CMD_TRACE_EN
   always_ff @(posedge CPU_clock) begin
      if (rst_n && cmd_valid_q)
         $display("%t : CMD : %s %0d %0h %0h", $time,
                  (cmd_q == CMD_PRE) ? "PRE" : (cmd_q == CMD_ACT) ? "ACT" :
                  (cmd_wr_q ? "WR" : "RD"),
                  cmd_bank_q, cmd_row_q, cmd_col_q);
      if (rst_n && bus.req_valid && !req_ready_q)
         $display("%t : DROP : %0h", $time, bus.req.address);
   end
`else
   // tracing compiled out
`endif

endmodule

// File: tb/tb_dram_cmd_sched.sv
// Scoreboard bench for dram_cmd_sched: directed requests push expected commands/done pulses,
// a negedge monitor pops and compares them against what the DUT presents.
module tb_dram_cmd_sched;

   localparam logic [1:0] OP_READ  = 2'd0;
   localparam logic [1:0] OP_WRITE = 2'd1;
   localparam logic [1:0] OP_IFET  = 2'd2;
   localparam logic [1:0] C_PRE = 2'd1, C_ACT = 2'd2, C_CAS = 2'd3;
   localparam int K_MISS = 0, K_HIT = 1, K_CONF = 2, K_ABORT = 3;

   typedef struct {
      int          cyc;
      bit          is_done;
      logic [1:0]  cmd;
      logic        wr;
      logic [1:0]  bank;
      logic [14:0] row;
      logic [9:0]  col;
   } ev_t;

   logic CPU_clock;
   logic rst_n;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   ev_t  exp_q[$];

   dram_cmd_sched_if bus ();

   dram_cmd_sched #(
      .ADDR_W(33), .NUM_BANKS(4), .T_RP(4), .T_RCD(4), .T_CAS(6), .T_BURST(4)
   ) dut (
      .CPU_clock(CPU_clock),
      .rst_n    (rst_n),
      .bus      (bus.slave)
   );

   initial begin
      CPU_clock = 1'b0;
      forever #5 CPU_clock = ~CPU_clock;
   end

   always @(posedge CPU_clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic check_ev(input bit d);
      ev_t e;
      bit  ok;
      n_chk++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL unexpected_%s: cmd=%0d bank=%0d row=%0h col=%0h at cycle %0d, nothing expected",
                  d ? "done" : "cmd", bus.cmd, bus.cmd_bank, bus.cmd_row, bus.cmd_col, cyc);
      end else begin
         e  = exp_q.pop_front();
         ok = (e.is_done == d) && (e.cyc == cyc);
         if (!d)
            ok = ok && bus.cmd == e.cmd && bus.cmd_bank == e.bank && bus.cmd_row == e.row &&
                 bus.cmd_col == e.col && (e.cmd != C_CAS || bus.cmd_wr == e.wr);
         if (!ok) begin
            n_fail++;
            $display("FAIL event: got done=%0d cmd=%0d wr=%0d bank=%0d row=%0h col=%0h cyc=%0d, expected done=%0d cmd=%0d wr=%0d bank=%0d row=%0h col=%0h cyc=%0d",
                     d, bus.cmd, bus.cmd_wr, bus.cmd_bank, bus.cmd_row, bus.cmd_col, cyc,
                     e.is_done, e.cmd, e.wr, e.bank, e.row, e.col, e.cyc);
         end
      end
   endtask

   always @(negedge CPU_clock) begin
      if (rst_n) begin
         if (bus.cmd_valid) check_ev(1'b0);
         if (bus.done)      check_ev(1'b1);
      end
   end

   task automatic push_cmd(input int c, input logic [1:0] k, input logic wr,
                           input logic [1:0] b, input logic [14:0] r, input logic [9:0] cl);
      ev_t e;
      e.cyc = c; e.is_done = 1'b0; e.cmd = k; e.wr = wr; e.bank = b; e.row = r; e.col = cl;
      exp_q.push_back(e);
   endtask

   task automatic push_done(input int c);
      ev_t e;
      e.cyc = c; e.is_done = 1'b1; e.cmd = 2'd0; e.wr = 1'b0; e.bank = '0; e.row = '0; e.col = '0;
      exp_q.push_back(e);
   endtask

   // Called at a negedge; the accept edge is the following posedge (cycle a = cyc now).
   task automatic txn(input logic [1:0] op, input logic [32:0] addr, input int kind,
                      input logic [1:0] b, input logic [14:0] r, input logic [9:0] cl);
      int   a;
      logic wr;
      a  = cyc;
      wr = (op == OP_WRITE);
      check("req_ready_before_accept", 32'(bus.req_ready), 32'd1);
      case (kind)
         K_MISS: begin
            push_cmd(a + 1, C_ACT, wr, b, r, cl);
            push_cmd(a + 5, C_CAS, wr, b, r, cl);
            push_done(a + 15);
         end
         K_HIT: begin
            push_cmd(a + 1, C_CAS, wr, b, r, cl);
            push_done(a + 11);
         end
         K_CONF: begin
            push_cmd(a + 1, C_PRE, wr, b, r, cl);
            push_cmd(a + 5, C_ACT, wr, b, r, cl);
            push_cmd(a + 9, C_CAS, wr, b, r, cl);
            push_done(a + 19);
         end
         default: push_cmd(a + 1, C_ACT, wr, b, r, cl);
      endcase
      bus.req.opcode          = op;
      bus.req.address         = addr;
      bus.req.CPU_clock_count = 64'(a);
      bus.req_valid           = 1'b1;
      @(negedge CPU_clock);
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_done();
      bit seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge CPU_clock);
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check("done_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req       = '0;
      @(negedge CPU_clock);
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
      check("rst_cmd",       32'(bus.cmd), 32'd0);
      check("rst_cmd_wr",    32'(bus.cmd_wr), 32'd0);
      check("rst_bank_row_col", {5'd0, bus.cmd_bank, bus.cmd_row, bus.cmd_col}, 32'd0);
      check("rst_done",      32'(bus.done), 32'd0);
      check("rst_drop_cnt",  32'(bus.drop_cnt), 32'd0);
      rst_n = 1'b1;
      while (cyc < 10) @(negedge CPU_clock);

      // miss: ACT 11, CAS 15, done 25
      txn(OP_READ, 33'h0_0004_0040, K_MISS, 2'd1, 15'd1, 10'd0);
      wait_done();
      // row hit issued back-to-back at the done cycle
      txn(OP_WRITE, 33'h0_0004_0140, K_HIT, 2'd1, 15'd1, 10'd1);
      wait_done();
      // row conflict in bank 1
      txn(OP_READ, 33'h0_0008_0040, K_CONF, 2'd1, 15'd2, 10'd0);
      wait_done();
      // interleave bank 0 / bank 1, then revisit bank 0's open row
      txn(OP_READ, 33'h0_000C_0500, K_MISS, 2'd0, 15'd3, 10'd5);
      wait_done();
      txn(OP_IFET, 33'h0_0004_0040, K_CONF, 2'd1, 15'd1, 10'd0);
      wait_done();
      txn(OP_WRITE, 33'h0_000C_0700, K_HIT, 2'd0, 15'd3, 10'd7);
      wait_done();

      // three requests while busy are dropped without issuing commands
      txn(OP_READ, 33'h0_0010_0080, K_MISS, 2'd2, 15'd4, 10'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge CPU_clock);
         bus.req.address = 33'h0_0018_0000 + 33'(i);
         bus.req_valid   = 1'b1;
         @(negedge CPU_clock);
         bus.req_valid = 1'b0;
      end
      wait_done();
      check("drop_cnt_three", 32'(bus.drop_cnt), 32'd3);

      // reset during WAIT_RCD aborts the sequence and forgets open rows
      txn(OP_READ, 33'h0_0014_00C0, K_ABORT, 2'd3, 15'd5, 10'd0);
      @(negedge CPU_clock);
      #2 rst_n = 1'b0;
      #1;
      check("abort_cmd_valid",  32'(bus.cmd_valid), 32'd0);
      check("abort_req_ready",  32'(bus.req_ready), 32'd0);
      check("abort_drop_cnt",   32'(bus.drop_cnt), 32'd0);
      repeat (3) @(negedge CPU_clock);
      rst_n = 1'b1;
      repeat (15) @(negedge CPU_clock);
      txn(OP_READ, 33'h0_0004_0040, K_MISS, 2'd1, 15'd1, 10'd0);
      wait_done();

      repeat (3) @(negedge CPU_clock);
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
